// File: rtl/conv_pkg.sv
// Shared types and constants for the conv engine and its downstream pooling stage.
package conv_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;

    localparam logic [3:0] WE_ALL  = 4'hF;
    localparam logic [3:0] WE_NONE = 4'h0;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StDrain,
        StWrite,
        StDone
    } pool_state_e;

endpackage

// File: rtl/conv_maxpool_if.sv
// Dual-BRAM port bundle (bram_sim protocol): M0 is the source map, M1 the destination map.
interface conv_maxpool_if;
    import conv_pkg::*;

    logic              M0_R_req;
    logic [ADDR_W-1:0] M0_addr;
    logic [DATA_W-1:0] M0_R_data;
    logic [3:0]        M0_W_req;
    logic [DATA_W-1:0] M0_W_data;
    logic              M1_R_req;
    logic [ADDR_W-1:0] M1_addr;
    logic [DATA_W-1:0] M1_R_data;
    logic [3:0]        M1_W_req;
    logic [DATA_W-1:0] M1_W_data;

    modport master (
        output M0_R_req, M0_addr, M0_W_req, M0_W_data,
        output M1_R_req, M1_addr, M1_W_req, M1_W_data,
        input  M0_R_data, M1_R_data
    );

    modport slave (
        input  M0_R_req, M0_addr, M0_W_req, M0_W_data,
        input  M1_R_req, M1_addr, M1_W_req, M1_W_data,
        output M0_R_data, M1_R_data
    );

endinterface

// File: rtl/pool_addr_gen.sv
// Window/tap counters for 2x2 stride-2 pooling and the matching source/destination addresses.
module pool_addr_gen
    import conv_pkg::*;
#(
    parameter int unsigned FM_W     = 28,
    parameter int unsigned FM_H     = 28,
    parameter int unsigned CH       = 1,
    parameter int unsigned SRC_BASE = 0,
    parameter int unsigned DST_BASE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              tap_inc_i,
    input  logic              win_adv_i,
    output logic [1:0]        tap_o,
    output logic              last_tap_o,
    output logic              last_win_o,
    output logic [ADDR_W-1:0] src_addr_o,
    output logic [ADDR_W-1:0] dst_addr_o
);

    localparam int unsigned OW = FM_W / 2;
    localparam int unsigned OH = FM_H / 2;

    localparam logic [ADDR_W-1:0] SrcChStride = ADDR_W'(FM_H * FM_W);
    localparam logic [ADDR_W-1:0] SrcRowStride = ADDR_W'(FM_W);
    localparam logic [ADDR_W-1:0] DstChStride = ADDR_W'(OH * OW);
    localparam logic [ADDR_W-1:0] DstRowStride = ADDR_W'(OW);
    localparam logic [ADDR_W-1:0] XLast = ADDR_W'(OW) - 32'd1;
    localparam logic [ADDR_W-1:0] RLast = ADDR_W'(OH) - 32'd1;
    localparam logic [ADDR_W-1:0] CLast = ADDR_W'(CH) - 32'd1;

    logic [1:0]        tap_q, tap_d;
    logic [ADDR_W-1:0] x_q, x_d;
    logic [ADDR_W-1:0] r_q, r_d;
    logic [ADDR_W-1:0] c_q, c_d;

    logic x_wrap, r_wrap, c_wrap;

    assign x_wrap = (x_q == XLast);
    assign r_wrap = (r_q == RLast);
    assign c_wrap = (c_q == CLast);

    always_comb begin
        tap_d = tap_q;
        x_d   = x_q;
        r_d   = r_q;
        c_d   = c_q;
        if (clr_i) begin
            tap_d = '0;
            x_d   = '0;
            r_d   = '0;
            c_d   = '0;
        end else begin
            // tap wraps 3 -> 0 on its own, ready for the next window
            if (tap_inc_i) tap_d = tap_q + 2'd1;
            if (win_adv_i) begin
                x_d = x_wrap ? '0 : x_q + 32'd1;
                if (x_wrap) begin
                    r_d = r_wrap ? '0 : r_q + 32'd1;
                    if (r_wrap) c_d = c_wrap ? '0 : c_q + 32'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tap_q <= '0;
            x_q   <= '0;
            r_q   <= '0;
            c_q   <= '0;
        end else begin
            tap_q <= tap_d;
            x_q   <= x_d;
            r_q   <= r_d;
            c_q   <= c_d;
        end
    end

    assign tap_o      = tap_q;
    assign last_tap_o = (tap_q == 2'd3);
    assign last_win_o = x_wrap && r_wrap && c_wrap;

    // tap[1] selects the lower row of the window, tap[0] the right column
    assign src_addr_o = ADDR_W'(SRC_BASE) + c_q * SrcChStride
                      + {r_q[ADDR_W-2:0], tap_q[1]} * SrcRowStride
                      + {x_q[ADDR_W-2:0], tap_q[0]};

    assign dst_addr_o = ADDR_W'(DST_BASE) + c_q * DstChStride + r_q * DstRowStride + x_q;

endmodule

// File: rtl/conv_maxpool.sv
// 2x2 stride-2 max pooling from the conv output BRAM (M0) into a second BRAM (M1).
// Build option MAXPOOL_RELU_EN clamps every tap to >= 0 before the compare (ReLU + maxpool).
module conv_maxpool
    import conv_pkg::*;
#(
    parameter int unsigned FM_W     = 28,
    parameter int unsigned FM_H     = 28,
    parameter int unsigned CH       = 1,
    parameter int unsigned SRC_BASE = 0,
    parameter int unsigned DST_BASE = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic           finish,
    conv_maxpool_if.master mem
);

    localparam bit Degenerate = (FM_W / 2 == 0) || (FM_H / 2 == 0) || (CH == 0);

    pool_state_e              state_q, state_d;
    logic signed [DATA_W-1:0] acc_q, acc_d;
    logic                     finish_q, finish_d;
    logic signed [DATA_W-1:0] tap_val;

    logic              clr, tap_inc, win_adv;
    logic [1:0]        tap;
    logic              last_tap, last_win;
    logic [ADDR_W-1:0] src_addr, dst_addr;
    logic              unused_m1_rdata;

    assign unused_m1_rdata = ^mem.M1_R_data;

    pool_addr_gen #(
        .FM_W     (FM_W),
        .FM_H     (FM_H),
        .CH       (CH),
        .SRC_BASE (SRC_BASE),
        .DST_BASE (DST_BASE)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (clr),
        .tap_inc_i  (tap_inc),
        .win_adv_i  (win_adv),
        .tap_o      (tap),
        .last_tap_o (last_tap),
        .last_win_o (last_win),
        .src_addr_o (src_addr),
        .dst_addr_o (dst_addr)
    );

`ifdef MAXPOOL_RELU_EN
    assign tap_val = mem.M0_R_data[DATA_W-1] ? '0 : $signed(mem.M0_R_data);
`else
    assign tap_val = $signed(mem.M0_R_data);
`endif

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        finish_d = finish_q;
        clr      = 1'b0;
        tap_inc  = 1'b0;
        win_adv  = 1'b0;

        // Read data lags the request by one cycle: taps 1..3 and DRAIN see taps 0..3
        if ((state_q == StRead && tap != 2'd0) || state_q == StDrain) begin
            if (state_q == StRead && tap == 2'd1) begin
                acc_d = tap_val;
            end else if (tap_val > acc_q) begin
                acc_d = tap_val;
            end
        end

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    clr      = 1'b1;
                    finish_d = Degenerate;
                    state_d  = Degenerate ? StDone : StRead;
                end
            end
            StRead: begin
                tap_inc = 1'b1;
                if (last_tap) state_d = StDrain;
            end
            StDrain: state_d = StWrite;
            StWrite: begin
                win_adv = 1'b1;
                if (last_win) begin
                    state_d  = StDone;
                    finish_d = 1'b1;
                end else begin
                    state_d = StRead;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            finish_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            finish_q <= finish_d;
        end
    end

    assign finish = finish_q;

    assign mem.M0_R_req  = (state_q == StRead);
    assign mem.M0_addr   = (state_q == StRead) ? src_addr : '0;
    assign mem.M0_W_req  = WE_NONE;
    assign mem.M0_W_data = '0;
    assign mem.M1_R_req  = 1'b0;
    assign mem.M1_W_req  = (state_q == StWrite) ? WE_ALL : WE_NONE;
    assign mem.M1_addr   = (state_q == StWrite) ? dst_addr : '0;
    assign mem.M1_W_data = (state_q == StWrite) ? acc_q : '0;

endmodule

// File: tb/tb_conv_maxpool.sv
// Scoreboard bench: three conv_maxpool builds (4x4x1, 5x5x2 with bases, 1x4 degenerate).
module tb_conv_maxpool;

    localparam logic [31:0] Sentinel = 32'hDEADBEEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, rst_c;
    logic start_a, start_b, start_c;
    logic finish_a, finish_b, finish_c;

    conv_maxpool_if a_if ();
    conv_maxpool_if b_if ();
    conv_maxpool_if c_if ();

    conv_maxpool #(.FM_W(4), .FM_H(4), .CH(1), .SRC_BASE(0), .DST_BASE(0)) u_dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .finish(finish_a), .mem(a_if)
    );
    conv_maxpool #(.FM_W(5), .FM_H(5), .CH(2), .SRC_BASE(8), .DST_BASE(40)) u_dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .finish(finish_b), .mem(b_if)
    );
    conv_maxpool #(.FM_W(1), .FM_H(4), .CH(1), .SRC_BASE(0), .DST_BASE(0)) u_dut_c (
        .clk(clk), .rst(rst_c), .start(start_c), .finish(finish_c), .mem(c_if)
    );

    logic [31:0] smem_a [16];
    logic [31:0] dmem_a [16];
    logic [31:0] smem_b [64];
    logic        clr_dmem_a = 1'b0;

    logic [63:0] exp_a[$];
    logic [63:0] exp_b[$];

    int n_pass = 0;
    int n_total = 0;
    int b_reads = 0;
    int b_bad = 0;
    int c_bad = 0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    // Memory models: registered read (data valid the cycle after the request), byte-enable write
    assign a_if.M1_R_data = '0;
    assign b_if.M1_R_data = '0;
    assign c_if.M1_R_data = '0;

    always @(posedge clk) begin
        if (a_if.M0_R_req) a_if.M0_R_data <= (a_if.M0_addr < 16) ? smem_a[a_if.M0_addr[3:0]] : Sentinel;
        if (b_if.M0_R_req) b_if.M0_R_data <= (b_if.M0_addr < 64) ? smem_b[b_if.M0_addr[5:0]] : Sentinel;
        if (c_if.M0_R_req) c_if.M0_R_data <= Sentinel;
        if (clr_dmem_a) begin
            for (int i = 0; i < 16; i++) dmem_a[i] <= Sentinel;
        end else if (a_if.M1_W_req == 4'hF && a_if.M1_addr < 16) begin
            dmem_a[a_if.M1_addr[3:0]] <= a_if.M1_W_data;
        end
    end

    // Monitor: pops the scoreboard on every destination write, traces source reads
    always @(negedge clk) begin
        logic [63:0] e;
        int unsigned loc;
        if (a_if.M1_W_req != 4'h0) begin
            if (exp_a.size() == 0) begin
                check("a_unexpected_write", {a_if.M1_addr, a_if.M1_W_data}, '1);
            end else begin
                e = exp_a.pop_front();
                check("a_write", {a_if.M1_W_req, a_if.M1_addr, a_if.M1_W_data}, {4'hF, e});
            end
        end
        if (b_if.M1_W_req != 4'h0) begin
            if (exp_b.size() == 0) begin
                check("b_unexpected_write", {b_if.M1_addr, b_if.M1_W_data}, '1);
            end else begin
                e = exp_b.pop_front();
                check("b_write", {b_if.M1_W_req, b_if.M1_addr, b_if.M1_W_data}, {4'hF, e});
            end
        end
        if (b_if.M0_R_req) begin
            b_reads++;
            loc = b_if.M0_addr - 32'd8;
            if (b_if.M0_addr < 8 || loc >= 50 || ((loc % 25) / 5) == 4 || (loc % 5) == 4) b_bad++;
        end
        if (c_if.M0_R_req || c_if.M1_W_req != 4'h0) c_bad++;
    end

    task automatic pulse_a();
        @(negedge clk) start_a = 1'b1;
        @(posedge clk) #1 start_a = 1'b0;
    endtask

    task automatic wait_finish_a(input string name, input int budget);
        for (int i = 0; i < budget && !finish_a; i++) @(posedge clk) #1;
        check(name, finish_a, 1'b1);
    endtask

    // Starts A and returns the cycle count at which finish first rose; optional extra start.
    task automatic timed_run_a(input int extra_at, output int first);
        first = 0;
        pulse_a();
        for (int k = 1; k <= 40 && first == 0; k++) begin
            @(posedge clk) #1;
            if (k == extra_at + 1) start_a = 1'b0;
            if (finish_a) first = k;
            if (k == extra_at) start_a = 1'b1;
        end
        start_a = 1'b0;
    endtask

    task automatic push_a_ramp();
        exp_a.push_back({32'd0, 32'd5});
        exp_a.push_back({32'd1, 32'd7});
        exp_a.push_back({32'd2, 32'd13});
        exp_a.push_back({32'd3, 32'd15});
    endtask

    task automatic load_a_ramp();
        for (int i = 0; i < 16; i++) smem_a[i] = 32'(i);
    endtask

    task automatic clear_dst_a();
        @(negedge clk) clr_dmem_a = 1'b1;
        @(negedge clk) clr_dmem_a = 1'b0;
    endtask

    initial begin
        int first;
        int neg_map [16];
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("a_reset_outputs", {finish_a, a_if.M0_R_req, a_if.M0_addr, a_if.M0_W_req,
              a_if.M0_W_data, a_if.M1_R_req, a_if.M1_addr, a_if.M1_W_req, a_if.M1_W_data}, '0);
        @(negedge clk) begin rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1; end

        // Ramp 0..15: exact 24-cycle latency and expected maxima
        load_a_ramp();
        clear_dst_a();
        push_a_ramp();
        timed_run_a(0, first);
        check("a_ramp_latency", first, 24);
        check("a_ramp_queue_empty", exp_a.size(), 0);
        check("a_ramp_mem", {dmem_a[0], dmem_a[1], dmem_a[2], dmem_a[3]},
              {32'd5, 32'd7, 32'd13, 32'd15});

        // Negative values: raw signed max versus ReLU-clamped max
        neg_map = '{-3, -1, 10, -20, -7, -2, -5, 4, 0, -8, -100, -50, -9, -4, -60, -70};
        for (int i = 0; i < 16; i++) smem_a[i] = neg_map[i];
`ifdef MAXPOOL_RELU_EN
        exp_a.push_back({32'd0, 32'd0});
        exp_a.push_back({32'd1, 32'd10});
        exp_a.push_back({32'd2, 32'd0});
        exp_a.push_back({32'd3, 32'd0});
`else
        exp_a.push_back({32'd0, 32'hFFFF_FFFF});
        exp_a.push_back({32'd1, 32'd10});
        exp_a.push_back({32'd2, 32'd0});
        exp_a.push_back({32'd3, 32'hFFFF_FFCE});
`endif
        pulse_a();
        wait_finish_a("a_neg_finish", 40);
        check("a_neg_queue_empty", exp_a.size(), 0);

        // Start pulsed mid-run is ignored; finish stays on the original cycle
        load_a_ramp();
        push_a_ramp();
        timed_run_a(10, first);
        check("a_midstart_latency", first, 24);
        check("a_midstart_queue_empty", exp_a.size(), 0);

        // Second start after finish: finish drops, identical results
        push_a_ramp();
        pulse_a();
        check("a_restart_finish_drop", finish_a, 1'b0);
        wait_finish_a("a_restart_finish", 40);
        check("a_restart_queue_empty", exp_a.size(), 0);

        // Reset asserted during the WRITE of output 2
        clear_dst_a();
        exp_a.push_back({32'd0, 32'd5});
        exp_a.push_back({32'd1, 32'd7});
        pulse_a();
        for (int i = 0; i < 40 && !(a_if.M1_W_req != 4'h0 && a_if.M1_addr == 32'd2); i++)
            @(posedge clk) #1;
        check("a_write2_reached", {a_if.M1_W_req, a_if.M1_addr}, {4'hF, 32'd2});
        rst_a = 1'b0;
        #1;
        check("a_midreset_outputs", {finish_a, a_if.M0_R_req, a_if.M0_addr, a_if.M0_W_req,
              a_if.M0_W_data, a_if.M1_R_req, a_if.M1_addr, a_if.M1_W_req, a_if.M1_W_data}, '0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_a = 1'b1;
        check("a_midreset_mem", {dmem_a[0], dmem_a[1], dmem_a[2], dmem_a[3]},
              {32'd5, 32'd7, Sentinel, Sentinel});
        check("a_midreset_queue_empty", exp_a.size(), 0);
        push_a_ramp();
        pulse_a();
        wait_finish_a("a_postreset_finish", 40);
        check("a_postreset_mem", {dmem_a[0], dmem_a[1], dmem_a[2], dmem_a[3]},
              {32'd5, 32'd7, 32'd13, 32'd15});

        // 5x5x2 with bases: odd row/col skipped, channel 1 at DST_BASE+4..7
        for (int c = 0; c < 2; c++)
            for (int y = 0; y < 5; y++)
                for (int x = 0; x < 5; x++)
                    smem_b[8 + c * 25 + y * 5 + x] = (c == 0) ? y * 10 + x : -(y * 10 + x) - 1;
        exp_b.push_back({32'd40, 32'd11});
        exp_b.push_back({32'd41, 32'd13});
        exp_b.push_back({32'd42, 32'd31});
        exp_b.push_back({32'd43, 32'd33});
`ifdef MAXPOOL_RELU_EN
        for (int i = 44; i < 48; i++) exp_b.push_back({32'(i), 32'd0});
`else
        exp_b.push_back({32'd44, 32'hFFFF_FFFF});
        exp_b.push_back({32'd45, 32'hFFFF_FFFD});
        exp_b.push_back({32'd46, 32'hFFFF_FFEB});
        exp_b.push_back({32'd47, 32'hFFFF_FFE9});
`endif
        @(negedge clk) start_b = 1'b1;
        @(posedge clk) #1 start_b = 1'b0;
        for (int i = 0; i < 100 && !finish_b; i++) @(posedge clk) #1;
        check("b_finish", finish_b, 1'b1);
        check("b_queue_empty", exp_b.size(), 0);
        check("b_read_count", b_reads, 32);
        check("b_reads_in_window", b_bad, 0);

        // FM_W=1: finish on the next cycle with no memory traffic
        check("c_idle_finish", finish_c, 1'b0);
        @(negedge clk) start_c = 1'b1;
        @(posedge clk) #1 start_c = 1'b0;
        check("c_finish_next_cycle", finish_c, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        check("c_no_traffic", c_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
